// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
// Shared types and helpers for the ALU arbiter slice.
//   DEF_OP_WIDTH / DEF_DATA_WIDTH : default opcode and operand widths
//   MAX_REQ                       : largest supported requester count
//   alu_op_t                      : opcode type at the default width
//   req_idx_t                     : requester index, wide enough for MAX_REQ
//   rr_pick()                     : round-robin pick from a valid vector
package alu_arb_pkg;

  localparam int DEF_OP_WIDTH   = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int MAX_REQ        = 8;

  typedef logic [DEF_OP_WIDTH-1:0]     alu_op_t;
  typedef logic [$clog2(MAX_REQ)-1:0]  req_idx_t;

  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } rr_pick_t;

  // Returns the first set bit of vld at or above ptr, wrapping around
  // modulo n_req. Bits at or above n_req are ignored.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] vld,
                                       input req_idx_t ptr,
                                       input int n_req);
    rr_pick_t res;
    int       j;
    res.valid = 1'b0;
    res.idx   = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = (int'(ptr) + k) % n_req;
      if (k < n_req && !res.valid && vld[j[2:0]]) begin
        res.valid = 1'b1;
        res.idx   = req_idx_t'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_tag_fifo.sv
// alu_tag_fifo
// In-order FIFO of requester tags, one per operation in flight in the ALU.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_push, i_tag   : push a requester index
//   i_pop           : pop the head (ignored when empty)
//   o_head          : tag at the head of the FIFO
//   o_count         : number of stored tags (0..DEPTH)
//   o_empty, o_full : occupancy flags
module alu_tag_fifo
  import alu_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  req_idx_t                 i_tag,
  input  logic                     i_pop,
  output req_idx_t                 o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  req_idx_t        r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_COUNT);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted only when paired with a pop.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Tag storage needs no reset; entries are only read once pushed.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_tag;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one ALU among N_REQ requesters with round-robin issue and routes
// each in-order ALU result back to the requester that issued it.
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_req_vld / o_req_rdy     : per-requester request handshake
//   i_req_op / i_req_a / i_req_b : packed per-requester fields, requester 0 in LSBs
//   o_alu_act, o_alu_op/a/b   : issued operation (fields zero when idle)
//   i_alu_rdy                 : ALU can take an operation this cycle
//   i_ex_alu, i_ex_alu_vld    : ALU result, returned in issue order
//   o_res_vld, o_res_data     : one-hot result strobe and shared result bus
//   o_outstanding             : operations in flight
//   o_err                     : sticky error, result seen with nothing in flight
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OP_WIDTH   = DEF_OP_WIDTH,
  parameter int MAX_OUT    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_REQ-1:0]              i_req_vld,
  output logic [N_REQ-1:0]              o_req_rdy,
  input  logic [N_REQ*OP_WIDTH-1:0]     i_req_op,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_a,
  input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_b,
  output logic                          o_alu_act,
  output logic [OP_WIDTH-1:0]           o_alu_op,
  output logic [DATA_WIDTH-1:0]         o_alu_a,
  output logic [DATA_WIDTH-1:0]         o_alu_b,
  input  logic                          i_alu_rdy,
  input  logic [DATA_WIDTH-1:0]         i_ex_alu,
  input  logic                          i_ex_alu_vld,
  output logic [N_REQ-1:0]              o_res_vld,
  output logic [DATA_WIDTH-1:0]         o_res_data,
  output logic [$clog2(MAX_OUT):0]      o_outstanding,
  output logic                          o_err
);

  logic [MAX_REQ-1:0]     w_vld_ext;
  rr_pick_t               w_pick;
  logic                   w_issue;
  logic                   w_pop;
  logic                   w_empty;
  logic                   w_full;
  req_idx_t               w_head;
  logic [N_REQ-1:0]       w_head_onehot;
  req_idx_t               r_ptr;
  logic [N_REQ-1:0]       r_res_vld;
  logic [DATA_WIDTH-1:0]  r_res_data;
  logic                   r_err;

  // Widen the valid vector to the package's fixed search width.
  always_comb begin
    w_vld_ext              = '0;
    w_vld_ext[N_REQ-1:0]   = i_req_vld;
  end

  assign w_pick = rr_pick(w_vld_ext, r_ptr, N_REQ);

  // Fullness is judged on the current count only, so a completion in the
  // same cycle cannot open a slot combinationally.
  assign w_issue = i_alu_rdy && !w_full && w_pick.valid;

  // A result with nothing in flight is an error and is not popped.
  assign w_pop = i_ex_alu_vld && !w_empty;

  // Grant decode and operand mux; everything is zero while idle.
  always_comb begin
    o_req_rdy = '0;
    o_alu_act = w_issue;
    o_alu_op  = '0;
    o_alu_a   = '0;
    o_alu_b   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_issue && w_pick.idx == req_idx_t'(i)) begin
        o_req_rdy[i] = 1'b1;
        o_alu_op     = i_req_op[i*OP_WIDTH +: OP_WIDTH];
        o_alu_a      = i_req_a[i*DATA_WIDTH +: DATA_WIDTH];
        o_alu_b      = i_req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_head_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_head_onehot[i] = (w_head == req_idx_t'(i));
    end
  end

  alu_tag_fifo #(
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_issue),
    .i_tag   (w_pick.idx),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (o_outstanding),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // The round-robin pointer moves just past the winner, so the winner has
  // lowest priority on the next arbitration.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      if (w_pick.idx == req_idx_t'(N_REQ-1)) r_ptr <= '0;
      else                                   r_ptr <= w_pick.idx + req_idx_t'(1);
    end
  end

  // Result strobe lasts one cycle; the data bus keeps its last value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_res_vld  <= '0;
      r_res_data <= '0;
      r_err      <= 1'b0;
    end else begin
      r_res_vld <= w_pop ? w_head_onehot : '0;
      if (w_pop) r_res_data <= i_ex_alu;
      if (i_ex_alu_vld && w_empty) r_err <= 1'b1;
    end
  end

  assign o_res_vld  = r_res_vld;
  assign o_res_data = r_res_data;
  assign o_err      = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Drives four requesters and plays the role of the ALU (fixed-latency,
// in-order, with an optional hold). A queue-based model of the arbiter is
// compared with the DUT every cycle, and directed scenarios add literal
// expectations at key points.
module tb_alu_arbiter;

  localparam int NREQ   = 4;
  localparam int DW     = 8;
  localparam int OW     = 4;
  localparam int MAXOUT = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      reqVld;
  logic [NREQ-1:0]      reqRdy;
  logic [NREQ*OW-1:0]   reqOp;
  logic [NREQ*DW-1:0]   reqA;
  logic [NREQ*DW-1:0]   reqB;
  logic                 aluAct;
  logic [OW-1:0]        aluOp;
  logic [DW-1:0]        aluA;
  logic [DW-1:0]        aluB;
  logic                 aluRdy;
  logic [DW-1:0]        exAlu;
  logic                 exAluVld;
  logic [NREQ-1:0]      resVld;
  logic [DW-1:0]        resData;
  logic [2:0]           outstanding;
  logic                 err;

  int checks   = 0;
  int failures = 0;

  // Model state: pointer, queue of owners in flight, registered outputs.
  int          mPtr;
  int          mTags[$];
  logic [3:0]  mResVld;
  logic [7:0]  mResData;
  logic        mErr;
  bit          mKnown = 1'b0;
  int          cycle  = 0;

  // Bench-side ALU: results queued with the cycle they become due.
  typedef struct {
    logic [7:0] data;
    int         due;
  } aluEntry_t;
  aluEntry_t   pipe[$];
  bit          autoAlu = 1'b1;
  bit          aluHold = 1'b0;
  int          aluLat  = 2;

  logic [3:0]  dutGrants[$];
  logic [3:0]  fairExp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};

  always #5 clk = ~clk;

  alu_arbiter #(
    .N_REQ      (NREQ),
    .DATA_WIDTH (DW),
    .OP_WIDTH   (OW),
    .MAX_OUT    (MAXOUT)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_vld     (reqVld),
    .o_req_rdy     (reqRdy),
    .i_req_op      (reqOp),
    .i_req_a       (reqA),
    .i_req_b       (reqB),
    .o_alu_act     (aluAct),
    .o_alu_op      (aluOp),
    .o_alu_a       (aluA),
    .o_alu_b       (aluB),
    .i_alu_rdy     (aluRdy),
    .i_ex_alu      (exAlu),
    .i_ex_alu_vld  (exAluVld),
    .o_res_vld     (resVld),
    .o_res_data    (resData),
    .o_outstanding (outstanding),
    .o_err         (err)
  );

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Load one requester's opcode and operands.
  task automatic applyStimulus(input int r, input logic [3:0] op,
                               input logic [7:0] a, input logic [7:0] b);
    reqOp[r*OW +: OW] = op;
    reqA[r*DW +: DW]  = a;
    reqB[r*DW +: DW]  = b;
  endtask

  function automatic logic [7:0] aluCompute(input logic [3:0] op,
                                            input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic resetModel();
    mPtr     = 0;
    mTags.delete();
    mResVld  = '0;
    mResData = '0;
    mErr     = 1'b0;
    pipe.delete();
  endtask

  // Runs at the falling edge: compares every DUT output with the model,
  // then advances the model across the coming rising edge.
  task automatic checkModel();
    int          g;
    int          idx;
    int          h;
    bit          expIssue;
    bit          popOk;
    logic [3:0]  expRdy;
    logic [3:0]  expOp;
    logic [7:0]  expA;
    logic [7:0]  expB;
    aluEntry_t   ent;
    if (rst) begin
      resetModel();
      mKnown = 1'b1;
    end else if (mKnown) begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (mPtr + k) % NREQ;
        if (g < 0 && reqVld[idx]) g = idx;
      end
      expIssue = aluRdy && (mTags.size() < MAXOUT) && (g >= 0);
      expRdy = '0;
      expOp  = '0;
      expA   = '0;
      expB   = '0;
      if (expIssue) begin
        expRdy[g] = 1'b1;
        expOp     = reqOp[g*OW +: OW];
        expA      = reqA[g*DW +: DW];
        expB      = reqB[g*DW +: DW];
      end
      checkOutput("reqRdy",      32'(reqRdy),      32'(expRdy));
      checkOutput("aluAct",      32'(aluAct),      32'(expIssue));
      checkOutput("aluOp",       32'(aluOp),       32'(expOp));
      checkOutput("aluA",        32'(aluA),        32'(expA));
      checkOutput("aluB",        32'(aluB),        32'(expB));
      checkOutput("outstanding", 32'(outstanding), 32'(mTags.size()));
      checkOutput("resVld",      32'(resVld),      32'(mResVld));
      checkOutput("resData",     32'(resData),     32'(mResData));
      checkOutput("err",         32'(err),         32'(mErr));
      if (aluAct) dutGrants.push_back(reqRdy);

      popOk = exAluVld && (mTags.size() > 0);
      if (exAluVld && mTags.size() == 0) mErr = 1'b1;
      mResVld = '0;
      if (popOk) begin
        h = mTags.pop_front();
        mResVld[h] = 1'b1;
        mResData   = exAlu;
      end
      if (expIssue) begin
        mTags.push_back(g);
        mPtr = (g + 1) % NREQ;
        ent.data = aluCompute(expOp, expA, expB);
        ent.due  = cycle + aluLat;
        pipe.push_back(ent);
      end
    end
    cycle++;
  endtask

  // Bench ALU output for the new cycle.
  task automatic driveAlu();
    aluEntry_t ent;
    if (autoAlu) begin
      if (!aluHold && pipe.size() > 0 && pipe[0].due <= cycle) begin
        ent      = pipe.pop_front();
        exAluVld = 1'b1;
        exAlu    = ent.data;
      end else begin
        exAluVld = 1'b0;
      end
    end
  endtask

  // Check at the falling edge, then return 1 time unit after the rising edge.
  task automatic stepCycle();
    @(negedge clk);
    checkModel();
    @(posedge clk);
    #1;
    driveAlu();
  endtask

  task automatic doReset();
    reqVld = '0;
    rst    = 1'b1;
    stepCycle();
    rst    = 1'b0;
  endtask

  initial begin
    int cnt;
    rst      = 1'b1;
    reqVld   = '0;
    reqOp    = '0;
    reqA     = '0;
    reqB     = '0;
    aluRdy   = 1'b0;
    exAlu    = '0;
    exAluVld = 1'b0;
    #1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rstOutstanding", 32'(outstanding), 32'd0);
    checkOutput("rstResVld",      32'(resVld),      32'd0);
    checkOutput("rstResData",     32'(resData),     32'd0);
    checkOutput("rstErr",         32'(err),         32'd0);
    checkOutput("rstAluAct",      32'(aluAct),      32'd0);

    // Single requester, ALU latency 2: result appears three cycles later.
    $display("[TB] single requester");
    aluLat = 2;
    aluRdy = 1'b1;
    applyStimulus(0, OP_ADD, 8'h12, 8'h34);
    reqVld = 4'b0001;
    #1;
    checkOutput("singleAct",  32'(aluAct), 32'd1);
    checkOutput("singleRdy",  32'(reqRdy), 32'h1);
    checkOutput("singleA",    32'(aluA),   32'h12);
    checkOutput("singleB",    32'(aluB),   32'h34);
    stepCycle();
    reqVld = 4'b0000;
    #1;
    checkOutput("singleOut1", 32'(outstanding), 32'd1);
    stepCycle();
    checkOutput("singleOut2", 32'(outstanding), 32'd1);
    checkOutput("singleNoRes", 32'(resVld),     32'd0);
    stepCycle();
    checkOutput("singleResVld",  32'(resVld),      32'h1);
    checkOutput("singleResData", 32'(resData),     32'h46);
    checkOutput("singleOut3",    32'(outstanding), 32'd0);
    stepCycle();

    // Fairness: all requesters valid, pointer restarted at 0.
    $display("[TB] fairness");
    doReset();
    aluLat = 1;
    for (int r = 0; r < NREQ; r++) applyStimulus(r, OP_ADD, 8'(8'h10 * r), 8'(r + 1));
    dutGrants.delete();
    reqVld = 4'b1111;
    repeat (8) stepCycle();
    reqVld = 4'b0000;
    checkOutput("fairCount", 32'(dutGrants.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      checkOutput("fairGrant", 32'((i < dutGrants.size()) ? dutGrants[i] : 4'h0), 32'(fairExp[i]));
    for (int r = 0; r < NREQ; r++) begin
      cnt = 0;
      foreach (dutGrants[i]) if (dutGrants[i][r]) cnt++;
      checkOutput("fairPerReq", 32'(cnt), 32'd2);
    end
    repeat (3) stepCycle();

    // Backpressure: results withheld until four operations are in flight.
    $display("[TB] backpressure");
    aluHold = 1'b1;
    reqVld  = 4'b1111;
    repeat (4) stepCycle();
    #1;
    checkOutput("bpOutFull", 32'(outstanding), 32'd4);
    checkOutput("bpRdy",     32'(reqRdy),      32'd0);
    checkOutput("bpAct",     32'(aluAct),      32'd0);
    stepCycle();
    aluHold = 1'b0;
    stepCycle();
    aluHold = 1'b1;
    #1;
    checkOutput("bpComplVld", 32'(exAluVld), 32'd1);
    checkOutput("bpSameCyc",  32'(aluAct),   32'd0);
    stepCycle();
    checkOutput("bpResumeOut", 32'(outstanding), 32'd3);
    checkOutput("bpResumeAct", 32'(aluAct),      32'd1);
    stepCycle();
    reqVld  = 4'b0000;
    aluHold = 1'b0;
    repeat (6) stepCycle();

    // Ordering: requester 2 then requester 0, back to back.
    $display("[TB] ordering");
    aluLat = 1;
    applyStimulus(2, OP_OR, 8'hAA, 8'h00);
    reqVld = 4'b0100;
    stepCycle();
    applyStimulus(0, OP_XOR, 8'h55, 8'h00);
    reqVld = 4'b0001;
    stepCycle();
    reqVld = 4'b0000;
    checkOutput("ordRes1Vld",  32'(resVld),      32'h4);
    checkOutput("ordRes1Data", 32'(resData),     32'hAA);
    checkOutput("ordOut",      32'(outstanding), 32'd1);
    stepCycle();
    checkOutput("ordRes2Vld",  32'(resVld),  32'h1);
    checkOutput("ordRes2Data", 32'(resData), 32'h55);
    repeat (2) stepCycle();

    // Issue and completion in the same cycle with two in flight.
    $display("[TB] simultaneous issue and completion");
    aluLat = 2;
    applyStimulus(1, OP_ADD, 8'h10, 8'h01);
    reqVld = 4'b0010;
    stepCycle();
    applyStimulus(3, OP_ADD, 8'h20, 8'h02);
    reqVld = 4'b1000;
    stepCycle();
    applyStimulus(2, OP_ADD, 8'h30, 8'h03);
    reqVld = 4'b0100;
    checkOutput("simOutBefore", 32'(outstanding), 32'd2);
    checkOutput("simComplVld",  32'(exAluVld),    32'd1);
    stepCycle();
    reqVld = 4'b0000;
    checkOutput("simOutAfter", 32'(outstanding), 32'd2);
    checkOutput("simResVld",   32'(resVld),      32'h2);
    checkOutput("simResData",  32'(resData),     32'h11);
    repeat (4) stepCycle();

    // ALU not ready: nothing granted, pointer (now 3) holds.
    $display("[TB] alu not ready");
    aluRdy = 1'b0;
    reqVld = 4'b1111;
    #1;
    checkOutput("stallRdy", 32'(reqRdy), 32'd0);
    checkOutput("stallAct", 32'(aluAct), 32'd0);
    checkOutput("stallA",   32'(aluA),   32'd0);
    repeat (2) stepCycle();
    aluRdy = 1'b1;
    #1;
    checkOutput("stallResumeRdy", 32'(reqRdy), 32'h8);
    stepCycle();
    reqVld = 4'b0000;
    repeat (4) stepCycle();

    // Result with nothing in flight sets the sticky error.
    $display("[TB] error");
    autoAlu  = 1'b0;
    exAlu    = 8'h77;
    exAluVld = 1'b1;
    stepCycle();
    exAluVld = 1'b0;
    checkOutput("errSet",   32'(err),    32'd1);
    checkOutput("errNoRes", 32'(resVld), 32'd0);
    stepCycle();
    checkOutput("errSticky", 32'(err), 32'd1);
    autoAlu = 1'b1;

    // Reset in the middle of traffic clears everything, including the error.
    $display("[TB] reset mid-traffic");
    aluLat = 3;
    reqVld = 4'b1111;
    repeat (3) stepCycle();
    doReset();
    #1;
    checkOutput("midRstOut",     32'(outstanding), 32'd0);
    checkOutput("midRstErr",     32'(err),         32'd0);
    checkOutput("midRstResVld",  32'(resVld),      32'd0);
    checkOutput("midRstResData", 32'(resData),     32'd0);
    checkOutput("midRstRdy",     32'(reqRdy),      32'd0);
    aluLat = 1;
    applyStimulus(1, OP_SUB, 8'h50, 8'h08);
    reqVld = 4'b0010;
    stepCycle();
    reqVld = 4'b0000;
    stepCycle();
    checkOutput("postRstResVld",  32'(resVld),  32'h2);
    checkOutput("postRstResData", 32'(resData), 32'h48);
    repeat (2) stepCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
